window_gen: RTL and testbench

Streaming sliding-window generator that sits directly upstream of `proc_elem`. It accepts one pixel per handshake in raster order and holds `KERNEL_SIZE-1` line buffers plus a `KERNEL_SIZE`x`KERNEL_SIZE` shift window. It emits every fully-inside (no padding) window in the packed layout `proc_elem.img_in` expects. Per frame it produces `(IMG_HEIGHT-KERNEL_SIZE+1)*(IMG_WIDTH-KERNEL_SIZE+1)` windows.

---
 rtl/window_gen.sv | 154 +++++++++++++++
 tb/tb_window_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// window_gen: streaming sliding-window generator for a KERNEL_SIZE x KERNEL_SIZE kernel.
//
// Accepts one pixel per handshake in raster order, keeps KERNEL_SIZE-1 line buffers and a
// KERNEL_SIZE x KERNEL_SIZE shift window, and emits every fully-inside window (no padding).
// Window packing: win_out[KERNEL_SIZE-1-r][KERNEL_SIZE-1-c] is the pixel at offset (r, c)
// from the window's top-left, so a row-major {top-left .. bottom-right} concatenation matches.
// KERNEL_SIZE must be >= 2; IMG_WIDTH and IMG_HEIGHT must be >= KERNEL_SIZE.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   px_valid   px_in holds a valid pixel
//   px_ready   block can accept a pixel this cycle (combinational)
//   px_in      pixel, raster order
//   win_valid  win_out holds a complete window
//   win_ready  downstream accepts the window
//   win_out    packed window
//   win_last   high with the final window of a frame
module window_gen #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned PX_SIZE     = 8,
    parameter int unsigned IMG_WIDTH   = 8,
    parameter int unsigned IMG_HEIGHT  = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               px_valid,
    output logic                                               px_ready,
    input  logic [PX_SIZE-1:0]                                 px_in,
    output logic                                               win_valid,
    input  logic                                               win_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_out,
    output logic                                               win_last
);

    localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned LbRows = KERNEL_SIZE - 1;

    localparam logic [ColW-1:0] ColMax   = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowMax   = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(KERNEL_SIZE - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(KERNEL_SIZE - 1);

    typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] win_t;

    // Line buffers: row 0 holds the oldest image row.
    logic [PX_SIZE-1:0] lb_q  [LbRows][IMG_WIDTH];
    logic [PX_SIZE-1:0] lb_d  [LbRows][IMG_WIDTH];
    // Shift window indexed [row][col], row 0 = top, col 0 = left.
    logic [PX_SIZE-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
    logic [PX_SIZE-1:0] win_d [KERNEL_SIZE][KERNEL_SIZE];

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    win_t            win_out_q, win_out_d;
    logic            win_valid_q, win_valid_d;
    logic            win_last_q, win_last_d;

    logic px_fire;
    logic win_fire;
    logic col_last;
    logic row_last;
    logic win_done;

    always_comb begin
        px_ready = !win_valid_q || win_ready;
        px_fire  = px_valid && px_ready;
        win_fire = win_valid_q && win_ready;
        col_last = (col_q == ColMax);
        row_last = (row_q == RowMax);
        // Gating on col also hides stale columns carried over from the previous row.
        win_done = px_fire && (row_q >= RowFirst) && (col_q >= ColFirst);

        lb_d        = lb_q;
        win_d       = win_q;
        col_d       = col_q;
        row_d       = row_q;
        win_out_d   = win_out_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;

        if (px_fire) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < LbRows; r++) begin
                win_d[r][KERNEL_SIZE-1] = lb_q[r][col_q];
            end
            win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = px_in;

            // Column of the line buffers shifts up; the newest row lands at the bottom.
            for (int r = 0; r < LbRows - 1; r++) begin
                lb_d[r][col_q] = lb_q[r+1][col_q];
            end
            lb_d[LbRows-1][col_q] = px_in;

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end

        if (win_done) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_out_d[KERNEL_SIZE-1-r][KERNEL_SIZE-1-c] = win_d[r][c];
                end
            end
            win_valid_d = 1'b1;
            win_last_d  = col_last && row_last;
        end else if (win_fire) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < LbRows; r++) begin
                for (int c = 0; c < IMG_WIDTH; c++) begin
                    lb_q[r][c] <= '0;
                end
            end
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q       <= '0;
            row_q       <= '0;
            win_out_q   <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            lb_q        <= lb_d;
            win_q       <= win_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_out_q   <= win_out_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win_out   = win_out_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on a 4x4 image with a 3x3 kernel. A frame-level
// reference model stores the accepted image and cuts expected windows directly from it.
module tb_window_gen;

    localparam int K  = 3;
    localparam int P  = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WB = K * K * P;

    localparam logic [WB-1:0] WinA = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [WB-1:0] WinB = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
    localparam logic [WB-1:0] WinC = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    localparam logic [WB-1:0] WinD = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
    localparam logic [WB-1:0] WinE = {8'd17, 8'd18, 8'd19, 8'd21, 8'd22, 8'd23, 8'd25, 8'd26,
                                      8'd27};
    localparam logic [WB-1:0] WinR = {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109,
                                      8'd110, 8'd111};

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          px_valid;
    logic                          px_ready;
    logic [P-1:0]                  px_in;
    logic                          win_valid;
    logic                          win_ready;
    logic [K-1:0][K-1:0][P-1:0]    win_out;
    logic                          win_last;

    always #5 clk = ~clk;

    window_gen #(
        .KERNEL_SIZE (K),
        .PX_SIZE     (P),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_in     (px_in),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_out   (win_out),
        .win_last  (win_last)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [P-1:0]  img [H][W];
    int            m_row;
    int            m_col;
    logic [WB-1:0] exp_q[$];
    bit            exp_last_q[$];
    // Windows actually taken from the DUT, in order.
    logic [WB-1:0] got_q[$];
    bit            got_last_q[$];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] model_window(input int r0, input int c0);
        logic [K-1:0][K-1:0][P-1:0] w;
        for (int dr = 0; dr < K; dr++) begin
            for (int dc = 0; dc < K; dc++) begin
                w[K-1-dr][K-1-dc] = img[r0+dr][c0+dc];
            end
        end
        return w;
    endfunction

    function automatic int count_lasts();
        int n = 0;
        foreach (got_last_q[i]) n += int'(got_last_q[i]);
        return n;
    endfunction

    task automatic reset_model();
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        exp_last_q.delete();
        got_q.delete();
        got_last_q.delete();
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic v, input logic [P-1:0] p, input logic r, output bit acc);
        bit pending;
        bit pf;
        pending = (exp_q.size() != 0);
        check_bit("win_valid", win_valid, pending);
        if (pending) begin
            check_win("win_out", win_out, exp_q[0]);
            check_bit("win_last", win_last, exp_last_q[0]);
        end
        px_valid  = v;
        px_in     = p;
        win_ready = r;
        #1;
        check_bit("px_ready", px_ready, !pending || r);
        pf = v && (!pending || r);
        if (pending && r) begin
            got_q.push_back(win_out);
            got_last_q.push_back(win_last);
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
        end
        if (pf) begin
            img[m_row][m_col] = p;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                exp_q.push_back(model_window(m_row - K + 1, m_col - K + 1));
                exp_last_q.push_back(m_row == H - 1 && m_col == W - 1);
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end
        acc = pf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [P-1:0] p, input logic r);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 50) begin
            tick(1'b1, p, r, acc);
            n++;
        end
        check_bit("px_accept", acc, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        repeat (3) tick(1'b0, '0, 1'b1, acc);
        check_int("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_basic4(input string tag);
        check_int({tag, "_count"}, got_q.size(), 4);
        if (got_q.size() == 4) begin
            check_win({tag, "_w0"}, got_q[0], WinA);
            check_win({tag, "_w1"}, got_q[1], WinB);
            check_win({tag, "_w2"}, got_q[2], WinC);
            check_win({tag, "_w3"}, got_q[3], WinD);
            for (int i = 0; i < 4; i++) check_bit({tag, "_last"}, got_last_q[i], i == 3);
        end
    endtask

    initial begin
        bit acc;
        int fed;
        int cyc;

        rst_n     = 1'b0;
        px_valid  = 1'b0;
        px_in     = '0;
        win_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst_win_valid", win_valid, 1'b0);
        check_bit("rst_win_last", win_last, 1'b0);
        check_win("rst_win_out", win_out, '0);
        check_bit("rst_px_ready", px_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        reset_model();

        // Basic frame, full throughput.
        for (int p = 1; p <= 16; p++) begin
            send(P'(p), 1'b1);
            if (p == 10) check_bit("basic_no_valid_yet", win_valid, 1'b0);
            if (p == 11) begin
                check_bit("basic_first_valid", win_valid, 1'b1);
                check_win("basic_first_win", win_out, WinA);
            end
        end
        drain();
        check_basic4("basic");

        // Backpressure right after the first window.
        got_q.delete();
        got_last_q.delete();
        for (int p = 1; p <= 11; p++) send(P'(p), 1'b1);
        repeat (5) begin
            tick(1'b1, 8'd12, 1'b0, acc);
            check_bit("bp_px_ready", px_ready, 1'b0);
            check_win("bp_hold", win_out, WinA);
        end
        for (int p = 12; p <= 16; p++) send(P'(p), 1'b1);
        drain();
        check_basic4("bp");

        // Two frames back to back.
        got_q.delete();
        got_last_q.delete();
        for (int p = 1; p <= 32; p++) send(P'(p), 1'b1);
        drain();
        check_int("b2b_count", got_q.size(), 8);
        if (got_q.size() == 8) check_win("b2b_w4", got_q[4], WinE);
        check_int("b2b_lasts", count_lasts(), 2);

        // Reset mid-frame: once with a window pending, once early in the frame.
        for (int k = 0; k < 2; k++) begin
            for (int p = 1; p <= ((k == 0) ? 11 : 7); p++) send(P'(p), 1'b0);
            #2 rst_n = 1'b0;
            #1;
            check_bit("midrst_win_valid", win_valid, 1'b0);
            check_bit("midrst_px_ready", px_ready, 1'b1);
            @(negedge clk);
            rst_n = 1'b1;
            reset_model();
        end
        for (int p = 101; p <= 116; p++) send(P'(p), 1'b1);
        drain();
        check_int("midrst_count", got_q.size(), 4);
        if (got_q.size() != 0) check_win("midrst_first", got_q[0], WinR);

        // Sparse input: every other cycle idle.
        got_q.delete();
        got_last_q.delete();
        for (int p = 1; p <= 16; p++) begin
            tick(1'b0, P'($urandom), 1'b1, acc);
            send(P'(p), 1'b1);
        end
        drain();
        check_basic4("sparse");

        // Random pixels, random valid/ready over four frames.
        got_q.delete();
        got_last_q.delete();
        fed = 0;
        cyc = 0;
        while (fed < 4 * W * H && cyc < 2000) begin
            tick($urandom_range(0, 99) < 70, P'($urandom), $urandom_range(0, 99) < 60, acc);
            if (acc) fed++;
            cyc++;
        end
        check_int("rand_fed", fed, 4 * W * H);
        drain();
        check_int("rand_count", got_q.size(), 4 * (H - K + 1) * (W - K + 1));
        check_int("rand_lasts", count_lasts(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
